// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel read path: bank-count derivation,
// the per-request tag that travels alongside a memory read, and endian codes.
package sobel_pkg;

    // Widest bank index supported (NUM_BANKS up to 8).
    localparam int MAX_BANK_BITS = 3;

    // Endian mode encoding of the per-request endian flag.
    localparam logic ENDIAN_LITTLE = 1'b0;
    localparam logic ENDIAN_BIG    = 1'b1;

    // Travels with every accepted request until its memory data returns.
    typedef struct packed {
        logic                     valid;
        logic [MAX_BANK_BITS-1:0] bank;
        logic                     offset;
        logic                     big_endian;
    } tag_t;

    // log2 of the bank count (bank count is a power of two, 2..8).
    function automatic int bank_bits(input int num_banks);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if ((1 << i) < num_banks) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/sobel_rdata_fifo.sv
// Small synchronous FIFO holding realigned read words until the consumer
// takes them. The head reads as zero when empty; clear empties it at the edge.
module sobel_rdata_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for pointers and occupancy; clear takes priority.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (clear) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) wr_d = ptr_inc(wr_q);
            if (pop)  rd_d = ptr_inc(rd_q);
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage write; data is not reset, emptiness is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_q] <= din;
        end
    end

    assign head  = (count_q != '0) ? mem_q[rd_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/sobel_read_aligner.sv
// Converts byte-granular unaligned read requests into per-bank word
// addresses, realigns the fixed-latency bank data into address order with a
// per-request endian mode, and buffers results behind a credit-checked FIFO.
module sobel_read_aligner
    import sobel_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_BANKS   = 4,
    parameter int OUT_BYTES   = 4,
    parameter int MEM_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic                            req_big_endian,
    input  logic                            flush,
    output logic                            mem_rd_en,
    output logic [ADDR_WIDTH*NUM_BANKS-1:0] mem_addr,
    input  logic [16*NUM_BANKS-1:0]         mem_rdata,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [8*OUT_BYTES-1:0]          out_data
);

    localparam int BANK_BITS = bank_bits(NUM_BANKS);
    localparam int DEPTH     = MEM_LATENCY + 2;
    localparam int NBYTES    = 2 * NUM_BANKS;
    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int SUM_W     = 4;

    logic                  accept;
    logic                  byte_off;
    logic [BANK_BITS-1:0]  start_bank;
    logic [ADDR_WIDTH-1:0] row;
    tag_t                  new_tag;
    tag_t                  tag_q [MEM_LATENCY];
    tag_t                  ret_tag;
    logic [SUM_W-1:0]      inflight;
    logic [CNT_W-1:0]      fifo_count;
    logic [8*NBYTES-1:0]   stream;
    logic [8*OUT_BYTES-1:0] aligned;

    assign byte_off   = req_addr[0];
    assign start_bank = req_addr[BANK_BITS:1];
    assign row        = req_addr >> (BANK_BITS + 1);

    // Credits: buffered plus in-flight results may never exceed the FIFO depth.
    assign req_ready = reset && !flush &&
                       ((SUM_W'(fifo_count) + inflight) < SUM_W'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign mem_rd_en = accept;

    // Banks below the starting bank hold the tail of the read on the next row.
    always_comb begin
        mem_addr = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            mem_addr[i*ADDR_WIDTH +: ADDR_WIDTH] =
                row + {{(ADDR_WIDTH-1){1'b0}}, (i < int'(start_bank))};
        end
    end

    // Tag captured at accept for realignment when the data returns.
    always_comb begin
        new_tag            = '0;
        new_tag.valid      = accept;
        new_tag.bank       = MAX_BANK_BITS'(start_bank);
        new_tag.offset     = byte_off;
        new_tag.big_endian = req_big_endian;
    end

    // Tag delay line matching the memory latency; flush kills in-flight reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < MEM_LATENCY; k++) tag_q[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < MEM_LATENCY; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0] <= new_tag;
            for (int k = 1; k < MEM_LATENCY; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    assign ret_tag = tag_q[MEM_LATENCY-1];

    // Number of reads issued whose data has not yet entered the FIFO.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < MEM_LATENCY; k++) begin
            inflight = inflight + SUM_W'(tag_q[k].valid);
        end
    end

    // Rotate banks by the start bank and shift one byte for odd addresses,
    // giving bytes in address order; then pick the requested endian order.
    always_comb begin
        int idx;
        stream  = '0;
        aligned = '0;
        for (int k = 0; k < NBYTES; k++) begin
            idx = (2 * int'(ret_tag.bank) + int'(ret_tag.offset) + k) % NBYTES;
            stream[8*k +: 8] = mem_rdata[8*idx +: 8];
        end
        for (int j = 0; j < OUT_BYTES; j++) begin
            if (ret_tag.big_endian == ENDIAN_BIG) begin
                aligned[8*j +: 8] = stream[8*(OUT_BYTES-1-j) +: 8];
            end else begin
                aligned[8*j +: 8] = stream[8*j +: 8];
            end
        end
    end

    sobel_rdata_fifo #(
        .WIDTH (8*OUT_BYTES),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (ret_tag.valid),
        .pop   (out_valid && out_ready),
        .clear (flush),
        .din   (aligned),
        .head  (out_data),
        .count (fifo_count)
    );

    assign out_valid = (fifo_count != '0);

endmodule
